// File: rtl/bcd_cnt_ctrl_pkg.sv
// Shared constants for the BCD counter controller: register addresses,
// register bit positions and controller states.
package bcd_cnt_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_CMP  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CNT  = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_CLR      = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int STAT_MATCH   = 0;
  localparam int STAT_RUN     = 1;
  localparam int STAT_BAD_CMP = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_cnt_ctrl_digit.sv
// One decade stage of the BCD counter chain; carry fires when this stage
// rolls over from 9 so the next stage can advance.
module bcd_digit (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  input  logic       load0,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == 4'd9);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= 4'd0;
    end else if (clr || load0) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_cnt_ctrl.sv
// APB-programmable sequencer for a cascaded BCD counter: gates counting on
// tick, reloads or halts on compare match and raises a level interrupt.
module bcd_cnt_ctrl
  import bcd_cnt_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8,
  parameter int DIGITS         = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic                      tick,
  output logic [4*DIGITS-1:0]       cnt,
  output logic                      match,
  output logic                      irq
);

  localparam int CW = 4 * DIGITS;

  function automatic logic has_bad_nibble(input logic [CW-1:0] v);
    logic r;
    r = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  logic          access, addr_err, wr;
  logic          wr_ctrl, wr_cmp, wr_stat;
  logic          clr, run_tick, hit, reload, step;
  logic          en, periodic, irq_en, stat_match;
  logic [CW-1:0] cmp;
  state_t        state, state_nxt;
  logic [DIGITS:0] carry_chain;
  logic          carry_out_unused;

  assign pready   = 1'b1;
  assign access   = psel && penable;
  assign addr_err = paddr[APB_ADDR_WIDTH-1:2] != '0;
  assign wr       = access && pwrite && !addr_err;
  assign wr_ctrl  = wr && (paddr[1:0] == ADDR_CTRL);
  assign wr_cmp   = wr && (paddr[1:0] == ADDR_CMP);
  assign wr_stat  = wr && (paddr[1:0] == ADDR_STAT);

  // A CLR write overrides any tick in the same cycle, so it also masks match.
  assign clr      = wr_ctrl && pwdata[CTRL_CLR];
  assign run_tick = (state == RUN) && tick && !clr;
  assign hit      = (cnt == cmp);
  assign reload   = run_tick && hit;
  assign step     = run_tick && !hit;

  assign carry_chain[0]   = step;
  assign carry_out_unused = carry_chain[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .inc   (carry_chain[k]),
      .load0 (reload),
      .q     (cnt[4*k +: 4]),
      .carry (carry_chain[k+1])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en         <= 1'b0;
      periodic   <= 1'b0;
      irq_en     <= 1'b0;
      cmp        <= CW'(4'd9);
      stat_match <= 1'b0;
      match      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en       <= pwdata[CTRL_EN];
        periodic <= pwdata[CTRL_PERIODIC];
        irq_en   <= pwdata[CTRL_IRQ_EN];
      end
      if (reload && !periodic) en <= 1'b0;
      if (wr_cmp) cmp <= pwdata[CW-1:0];
      if (reload) stat_match <= 1'b1;
      else if (wr_stat && pwdata[STAT_MATCH]) stat_match <= 1'b0;
      match <= reload;
      irq   <= stat_match && irq_en;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (reload && !periodic) state_nxt = HALT;
        else if (!en)            state_nxt = IDLE;
      end
      HALT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prdata  = '0;
    pslverr = access && addr_err;
    if (access && !pwrite && !addr_err) begin
      case (paddr[1:0])
        ADDR_CTRL: begin
          prdata[CTRL_EN]       = en;
          prdata[CTRL_PERIODIC] = periodic;
          prdata[CTRL_IRQ_EN]   = irq_en;
        end
        ADDR_CMP: prdata[CW-1:0] = cmp;
        ADDR_STAT: begin
          prdata[STAT_MATCH]   = stat_match;
          prdata[STAT_RUN]     = (state == RUN);
          prdata[STAT_BAD_CMP] = has_bad_nibble(cmp);
        end
        ADDR_CNT: prdata[CW-1:0] = cnt;
        default:  prdata = '0;
      endcase
    end
  end

endmodule
